mult_test_sequencer: RTL and testbench
======================================

MULT_TEST_SEQUENCER -- requirements
Module: mult_test_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, giving the width of the operand and result RAM address.
REQ-002 The block SHALL have parameter LATENCY, default 4, giving the cycles from read issue to result write; legal range 1..32.
REQ-003 The block SHALL have parameter LANES, default 2, giving the number of interleaved channels; legal values 1, 2 and 4; LW = max(1, clog2(LANES)).
REQ-004 Port pll_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port start, input, 1 bit: single-cycle request to begin a sweep.
REQ-007 Port abort, input, 1 bit: stops issuing new reads.
REQ-008 Port loop_mode, input, 1 bit: when set, the sweep repeats until aborted.
REQ-009 Port num_vectors, input, ADDR_WIDTH+1 bits: number of vectors per sweep, 0..2^ADDR_WIDTH.
REQ-010 Ports rd_en (1 bit), rd_addr (ADDR_WIDTH bits) and rd_lane (LW bits), outputs: operand RAM read strobe, read address and read lane.
REQ-011 Ports wr_en (1 bit), wr_addr (ADDR_WIDTH bits) and wr_lane (LW bits), outputs: result RAM write strobe, write address and write lane.
REQ-012 Ports busy (1 bit) and done (1 bit), outputs: sweep active, and a one-cycle completion pulse.
REQ-013 Ports pass_count (32 bits) and cycle_count (32 bits), outputs: completed sweeps, and active cycles.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-015 In IDLE, start with num_vectors>0 SHALL latch num_vectors, clear pass_count, clear cycle_count and enter ISSUE on the next cycle.
REQ-016 In IDLE, start with num_vectors==0 SHALL enter DONE directly, with no rd_en.
REQ-017 In ISSUE, rd_en SHALL be 1 every cycle, and rd_addr SHALL run from 0 to N-1 (N is the latched num_vectors), incrementing by 1 per cycle.
REQ-018 rd_lane SHALL equal rd_addr modulo LANES; when LANES=1, rd_lane SHALL be 0.
REQ-019 wr_en, wr_addr and wr_lane SHALL equal rd_en, rd_addr and rd_lane delayed by exactly LATENCY cycles, through an internal shift line.
REQ-020 On the cycle after issuing address N-1 with loop_mode=0, the FSM SHALL go to DRAIN.
REQ-021 With loop_mode=1, the address after N-1 SHALL wrap to 0 with no idle cycle, and pass_count SHALL increment on the wrap cycle.
REQ-022 abort in ISSUE SHALL force rd_en to 0 from the next cycle and move the FSM to DRAIN; reads already issued SHALL still produce their writes.
REQ-023 If abort and the last-address issue coincide, the last read SHALL be issued and pass_count SHALL NOT increment.
REQ-024 DRAIN SHALL last until the shift line holds no valid entry (exactly LATENCY cycles), then go to DONE.
REQ-025 On a normal completion without abort, pass_count SHALL increment on the DRAIN-to-DONE transition.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 abort SHALL be ignored in IDLE, DRAIN and DONE.
REQ-030 pass_count and cycle_count SHALL saturate at 2^32-1 and SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-031 While resetn=0, the FSM SHALL be in IDLE and the shift line SHALL be flushed.
REQ-032 While resetn=0, every output SHALL be 0.
REQ-033 Reset mid-sweep SHALL discard all in-flight writes: no wr_en SHALL appear after resetn rises until a new sweep's writes arrive.

Configuration
REQ-034 With macro MULT_TEST_SEQUENCER_CYCLE_COUNT_EN defined, cycle_count SHALL increment once per cycle in ISSUE and DRAIN.
REQ-035 Without MULT_TEST_SEQUENCER_CYCLE_COUNT_EN, cycle_count SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-036 Single sweep, LATENCY=4, LANES=2, N=5, loop_mode=0: start -> rd_addr 0..4 with rd_lane 0,1,0,1,0; wr_addr 0..4 four cycles later; done 1 cycle after last wr_en; pass_count=1; cycle_count=9 with the macro defined.
REQ-037 num_vectors=0: start -> done on the next cycle, no rd_en or wr_en, busy never 1.
REQ-038 Loop mode, N=3, abort held one cycle after the 7th issue (rd_addr 0): no rd_en after that, the 7 pending writes complete, done pulses, pass_count=2.
REQ-039 Abort on the cycle issuing rd_addr=N-1=7 (N=8): the write to address 7 is still emitted, pass_count=0, done pulses once.
REQ-040 resetn asserted 2 cycles into a LATENCY=8 sweep: all outputs 0 immediately; after release, no stray wr_en within 8 cycles.
REQ-041 start pulsed during DRAIN: ignored, latched N unchanged; a start pulsed after done is accepted.

Source files
------------

// File: rtl/mult_test_sequencer.sv
// Multiplier test sequencer: sweeps operand RAM reads and replays them as result writes after LATENCY cycles.
// Optional cycle counter enabled by defining MULT_TEST_SEQUENCER_CYCLE_COUNT_EN.
module mult_test_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 4,
  parameter int LANES      = 2,
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  pll_clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loop_mode,
  input  logic [ADDR_WIDTH:0]   num_vectors,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [LW-1:0]         rd_lane,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [LW-1:0]         wr_lane,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pass_count,
  output logic [31:0]           cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LW-1:0]         lane;
  } slot_t;

  state_t                state_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;
  logic [31:0]           pass_q;

  slot_t                 line_q [LATENCY];
  slot_t                 line_d [LATENCY];
  logic                  line_empty_d;
  logic                  last_addr;

  assign last_addr = ({1'b0, rd_addr_q} == (n_q - 1'b1));

  // Lanes are a power of two, so the modulo is just the low address bits.
  if (LANES == 1) begin : g_one_lane
    assign rd_lane = '0;
  end else begin : g_multi_lane
    assign rd_lane = rd_addr_q[LW-1:0];
  end

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    line_d[0] = {rd_en_q, rd_addr_q, rd_lane};
    for (int i = 1; i < LATENCY; i++) begin
      line_d[i] = line_q[i-1];
    end
    line_empty_d = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      if (line_d[i].valid) line_empty_d = 1'b0;
    end
  end

  // NOTE: the shift line is built from flops, not RAM, so it is reset to guarantee no stale write survives.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) line_q[i] <= line_d[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pass_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_vectors != '0) begin
              state_q   <= S_ISSUE;
              n_q       <= num_vectors;
              rd_addr_q <= '0;
              rd_en_q   <= 1'b1;
              busy_q    <= 1'b1;
              aborted_q <= 1'b0;
              pass_q    <= '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Abort wins over the wrap, so a coinciding last issue never counts a pass.
          if (abort) begin
            state_q   <= S_DRAIN;
            rd_en_q   <= 1'b0;
            aborted_q <= 1'b1;
          end else if (last_addr) begin
            if (loop_mode) begin
              rd_addr_q <= '0;
              if (pass_q != '1) pass_q <= pass_q + 32'd1;
            end else begin
              state_q <= S_DRAIN;
              rd_en_q <= 1'b0;
            end
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (line_empty_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!aborted_q && pass_q != '1) pass_q <= pass_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULT_TEST_SEQUENCER_CYCLE_COUNT_EN
  logic [31:0] cycle_q;

  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      cycle_q <= '0;
    end else if (state_q == S_IDLE && start && num_vectors != '0) begin
      cycle_q <= '0;
    end else if (busy_q && cycle_q != '1) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign wr_en      = line_q[LATENCY-1].valid;
  assign wr_addr    = line_q[LATENCY-1].addr;
  assign wr_lane    = line_q[LATENCY-1].lane;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_mult_test_sequencer.sv
// Self-checking bench for mult_test_sequencer: table-driven sweeps plus reset, zero-length and drain corner cases.
module tb_mult_test_sequencer;

  localparam int AW    = 9;
  localparam int LAT   = 4;
  localparam int LANES = 2;
  localparam int LW    = 1;

  logic          pll_clock = 1'b0;
  logic          resetn;
  logic          start;
  logic          abort;
  logic          loop_mode;
  logic [AW:0]   num_vectors;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_lane;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_lane;
  logic          busy;
  logic          done;
  logic [31:0]   pass_count;
  logic [31:0]   cycle_count;

  mult_test_sequencer #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT),
    .LANES     (LANES)
  ) dut (
    .pll_clock  (pll_clock),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .loop_mode  (loop_mode),
    .num_vectors(num_vectors),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_lane    (rd_lane),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_lane    (wr_lane),
    .busy       (busy),
    .done       (done),
    .pass_count (pass_count),
    .cycle_count(cycle_count)
  );

  always #5 pll_clock = ~pll_clock;

  typedef struct {
    int n;
    bit loop;
    int abort_at;
    int exp_reads;
    int exp_pass;
  } vec_t;

  typedef struct {
    int     addr;
    int     lane;
    longint due;
  } wr_exp_t;

  int        n_assert = 0;
  int        n_fail   = 0;
  longint    cyc      = 0;
  bit        exp_active = 1'b0;
  int        exp_n, exp_addr;
  int        rd_count, wr_count, done_count, busy_cnt;
  longint    first_rd_cyc, last_wr_cyc, done_cyc;
  wr_exp_t   wq[$];
  wr_exp_t   e;
  vec_t      tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rd_count     = 0;
    wr_count     = 0;
    done_count   = 0;
    busy_cnt     = 0;
    first_rd_cyc = -1;
    last_wr_cyc  = -1;
    done_cyc     = -1;
    wq.delete();
  endtask

  always @(posedge pll_clock) cyc <= cyc + 1;

  // Monitor: checks reads against the bench's address model and queues the writes they must produce.
  always @(negedge pll_clock) begin
    while (wq.size() > 0 && wq[0].due < cyc) begin
      check("wr_missing", 1'b0, 1'b1);
      void'(wq.pop_front());
    end
    if (rd_en) begin
      rd_count++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (!exp_active) begin
        check("rd_unexpected", 1'b1, 1'b0);
      end else begin
        check("rd_addr", rd_addr, exp_addr);
        check("rd_lane", rd_lane, exp_addr % LANES);
        wq.push_back('{exp_addr, exp_addr % LANES, cyc + LAT});
        exp_addr = (exp_addr == exp_n - 1) ? 0 : exp_addr + 1;
      end
    end
    if (wr_en) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (wq.size() == 0) begin
        check("wr_unexpected", 1'b1, 1'b0);
      end else begin
        e = wq.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_lane", wr_lane, e.lane);
        check("wr_time", cyc, e.due);
      end
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_count++;
      done_cyc = cyc;
      check("busy_at_done", busy, 1'b0);
    end
  end

  task automatic wait_done();
    int guard = 0;
    while (done_count == 0 && guard < 5000) begin
      @(posedge pll_clock);
      guard++;
    end
    exp_active = 1'b0;
    repeat (3) @(posedge pll_clock);
  endtask

  task automatic run_sweep(input vec_t v, input bit start_in_drain);
    longint s;
    int     exp_cycles;
`ifdef MULT_TEST_SEQUENCER_CYCLE_COUNT_EN
    exp_cycles = v.exp_reads + LAT;
`else
    exp_cycles = 0;
`endif
    clear_stats();
    exp_n      = v.n;
    exp_addr   = 0;
    exp_active = 1'b1;
    @(negedge pll_clock);
    num_vectors = (AW+1)'(v.n);
    loop_mode   = v.loop;
    start       = 1'b1;
    s           = cyc;
    @(negedge pll_clock);
    start = 1'b0;
    if (v.abort_at >= 0) begin
      repeat (v.abort_at) @(negedge pll_clock);
      abort = 1'b1;
      @(negedge pll_clock);
      abort = 1'b0;
    end
    if (start_in_drain) begin
      repeat (v.n + 1) @(negedge pll_clock);
      start       = 1'b1;
      abort       = 1'b1;
      num_vectors = 9;
      @(negedge pll_clock);
      start = 1'b0;
      abort = 1'b0;
    end
    wait_done();
    check("done_count", done_count, 1);
    check("rd_count", rd_count, v.exp_reads);
    check("wr_count", wr_count, v.exp_reads);
    check("wq_empty", wq.size(), 0);
    check("first_rd_time", first_rd_cyc, s + 1);
    check("done_time", done_cyc, last_wr_cyc + 1);
    check("busy_cycles", busy_cnt, v.exp_reads + LAT);
    check("pass_count", pass_count, v.exp_pass);
    check("cycle_count", cycle_count, exp_cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s;
    tbl[0] = '{5,   1'b0, -1, 5,   1};
    tbl[1] = '{3,   1'b1,  6, 7,   2};
    tbl[2] = '{8,   1'b0,  7, 8,   0};
    tbl[3] = '{1,   1'b0, -1, 1,   1};
    tbl[4] = '{4,   1'b1,  1, 2,   0};
    tbl[5] = '{2,   1'b1,  5, 6,   2};
    tbl[6] = '{3,   1'b0,  0, 1,   0};
    tbl[7] = '{10,  1'b0,  3, 4,   0};
    tbl[8] = '{6,   1'b1, 11, 12,  1};
    tbl[9] = '{512, 1'b0, -1, 512, 1};

    resetn      = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    loop_mode   = 1'b0;
    num_vectors = '0;
    clear_stats();
    repeat (3) @(negedge pll_clock);
    check("rst_ctl", {rd_en, rd_addr, rd_lane, wr_en, wr_addr, wr_lane, busy, done}, 0);
    check("rst_pass", pass_count, 0);
    check("rst_cycle", cycle_count, 0);
    resetn = 1'b1;
    repeat (2) @(negedge pll_clock);

    for (int i = 0; i < 10; i++) run_sweep(tbl[i], 1'b0);

    // Zero-length sweep goes straight to DONE.
    clear_stats();
    exp_active = 1'b0;
    @(negedge pll_clock);
    num_vectors = '0;
    loop_mode   = 1'b0;
    start       = 1'b1;
    s           = cyc;
    @(negedge pll_clock);
    start = 1'b0;
    wait_done();
    check("zero_done_count", done_count, 1);
    check("zero_done_time", done_cyc, s + 1);
    check("zero_rd_count", rd_count, 0);
    check("zero_wr_count", wr_count, 0);
    check("zero_busy", busy_cnt, 0);

    // Start and abort during DRAIN are ignored; the next start after done is taken.
    run_sweep('{4, 1'b0, -1, 4, 1}, 1'b1);
    run_sweep('{2, 1'b0, -1, 2, 1}, 1'b0);

    // Reset two cycles into a sweep discards everything in flight.
    clear_stats();
    exp_n      = 20;
    exp_addr   = 0;
    exp_active = 1'b1;
    @(negedge pll_clock);
    num_vectors = 20;
    loop_mode   = 1'b0;
    start       = 1'b1;
    @(negedge pll_clock);
    start = 1'b0;
    @(negedge pll_clock);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_ctl", {rd_en, rd_addr, rd_lane, wr_en, wr_addr, wr_lane, busy, done}, 0);
    check("midrst_pass", pass_count, 0);
    check("midrst_cycle", cycle_count, 0);
    exp_active = 1'b0;
    clear_stats();
    repeat (2) @(negedge pll_clock);
    resetn = 1'b1;
    repeat (12) @(posedge pll_clock);
    check("postrst_wr_count", wr_count, 0);
    check("postrst_rd_count", rd_count, 0);
    check("postrst_done_count", done_count, 0);
    check("postrst_busy", busy_cnt, 0);

    run_sweep('{3, 1'b0, -1, 3, 1}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
